// File: rtl/sdram_pkg.sv
// sdram_pkg: shared state encoding and default widths for the SDRAM arbiter
package sdram_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
    localparam int ADDR_W_DEF = 22;
    localparam int DATA_W_DEF = 16;
endpackage

// File: rtl/sdram_rr_pick.sv
// sdram_rr_pick: two-way round-robin pick; rr names the client that wins a tie
module sdram_rr_pick (
    input  logic [1:0] req,
    input  logic       rr,
    output logic       valid,
    output logic       idx
);
    always_comb begin
        valid = |req;
        idx   = (&req) ? rr : req[1];
    end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-client arbiter issuing one read/write command at a time to an SDRAM controller
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 1024
) (
    input  logic                   iclk,
    input  logic                   ireset_n,
    input  logic [1:0]             ic_req,
    input  logic [1:0]             ic_we,
    input  logic [1:0][ADDR_W-1:0] ic_addr,
    input  logic [1:0][DATA_W-1:0] ic_wdata,
    output logic [1:0]             oc_ack,
    output logic [1:0]             oc_done,
    output logic                   oc_err,
    output logic [DATA_W-1:0]      oc_rdata,
    output logic                   owrite_req,
    output logic [ADDR_W-1:0]      owrite_address,
    output logic [DATA_W-1:0]      owrite_data,
    input  logic                   iwrite_ack,
    output logic                   oread_req,
    output logic [ADDR_W-1:0]      oread_address,
    input  logic [DATA_W-1:0]      iread_data,
    input  logic                   iread_ack,
    output logic                   obusy
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    arb_state_t    state;
    logic          rr;
    logic          g;
    logic [CW-1:0] cnt;
    logic          gv;
    logic          gi;
    logic          hit;
    logic          tmo;

    sdram_rr_pick u_pick (
        .req  (ic_req),
        .rr   (rr),
        .valid(gv),
        .idx  (gi)
    );

    // only the ack matching the outstanding command direction counts
    always_comb begin
        hit = (owrite_req & iwrite_ack) | (oread_req & iread_ack);
        tmo = cnt == CW'(TIMEOUT - 1);
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state          <= IDLE;
            rr             <= 1'b0;
            g              <= 1'b0;
            cnt            <= '0;
            oc_ack         <= '0;
            oc_done        <= '0;
            oc_err         <= 1'b0;
            oc_rdata       <= '0;
            owrite_req     <= 1'b0;
            owrite_address <= '0;
            owrite_data    <= '0;
            oread_req      <= 1'b0;
            oread_address  <= '0;
            obusy          <= 1'b0;
        end else begin
            oc_ack  <= '0;
            oc_done <= '0;
            oc_err  <= 1'b0;
            case (state)
                IDLE: if (gv) begin
                    state      <= BUSY;
                    g          <= gi;
                    cnt        <= '0;
                    obusy      <= 1'b1;
                    oc_ack[gi] <= 1'b1;
                    if (ic_we[gi]) begin
                        owrite_req     <= 1'b1;
                        owrite_address <= ic_addr[gi];
                        owrite_data    <= ic_wdata[gi];
                    end else begin
                        oread_req     <= 1'b1;
                        oread_address <= ic_addr[gi];
                    end
                end
                BUSY: if (hit || tmo) begin
                    state      <= DONE;
                    owrite_req <= 1'b0;
                    oread_req  <= 1'b0;
                    oc_done[g] <= 1'b1;
                    oc_err     <= ~hit;
                    rr         <= ~g;
                    if (oread_req && iread_ack) oc_rdata <= iread_data;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    obusy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
